// File: rtl/usb_pkg.sv
// rtl/usb_pkg.sv - shared USB line constants, packet limits and tx state encoding
package usb_pkg;

  localparam logic [1:0] LINE_J = 2'b10;
  localparam logic [1:0] LINE_K = 2'b01;
  localparam logic [1:0] LINE_X = 2'b00;

  localparam int DATA_BITS_DEF   = 101;
  localparam int HSHAKE_BITS_DEF = 8;

  // K/J map of the SYNC field, MSB is the first symbol on the wire (1 = J)
  localparam logic [7:0] SYNC_PATTERN = 8'b0101_0100;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_SYNC,
    TX_SEND,
    TX_EOP1,
    TX_EOP2,
    TX_EOPJ
  } tx_state_t;

  function automatic logic [1:0] sync_sym(input logic [2:0] idx);
    return SYNC_PATTERN[3'd7 - idx] ? LINE_J : LINE_K;
  endfunction

endpackage

// File: rtl/tx_dpdm_if.sv
// rtl/tx_dpdm_if.sv - NRZI bit stream from the encoder into the line driver
interface tx_dpdm_if;

  logic s_in;
  logic nrzi_valid;
  logic nrzi_last;
  logic nrzi_ready;

  modport master (output s_in, nrzi_valid, nrzi_last, input nrzi_ready);
  modport slave  (input s_in, nrzi_valid, nrzi_last, output nrzi_ready);

endinterface

// File: rtl/counter.sv
// rtl/counter.sv - small up counter with synchronous clear that can count in the clearing cycle
module counter #(
  parameter int WIDTH = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else begin
      q <= (clr ? '0 : q) + WIDTH'(en);
    end
  end

endmodule

// File: rtl/tx_dpdm.sv
// rtl/tx_dpdm.sv - USB transmit D+/D- driver: SYNC, NRZI payload, EOP, bus ownership
module tx_dpdm
  import usb_pkg::*;
#(
  parameter int DATA_BITS   = DATA_BITS_DEF,
  parameter int HSHAKE_BITS = HSHAKE_BITS_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         abort,
  input  logic         start_send,
  input  logic         send_hshake,
  tx_dpdm_if.slave     nrzi,
  output logic [1:0]   bus_out,
  output logic         bus_en,
  output logic         busy,
  output logic         tx_done,
  output logic         tx_error
);

  localparam logic [6:0] DATA_LIM = 7'(DATA_BITS);
  localparam logic [6:0] HS_LIM   = 7'(HSHAKE_BITS);

  tx_state_t  state;
  logic       hshake;
  logic [6:0] cnt;
  logic       cnt_clr;
  logic       cnt_en;

  logic       sync_last;
  logic       window;
  logic       xfer;
  logic       underrun;
  logic [6:0] bit_cnt_nxt;
  logic       at_limit;
  logic       finish;

  // The last SYNC cycle already accepts the first payload bit so it lands right after the final K.
  assign sync_last   = (state == TX_SYNC) && (cnt == 7'd7);
  assign window      = sync_last || (state == TX_SEND);
  assign nrzi.nrzi_ready = window;
  assign xfer        = window && nrzi.nrzi_valid;
  assign underrun    = window && !nrzi.nrzi_valid;
  assign bit_cnt_nxt = ((state == TX_SEND) ? cnt : 7'd0) + 7'd1;
  assign at_limit    = bit_cnt_nxt == (hshake ? HS_LIM : DATA_LIM);
  assign finish      = xfer && (nrzi.nrzi_last || at_limit);

  counter #(.WIDTH(7)) u_counter (
    .clk (clk),
    .rst (rst),
    .clr (cnt_clr),
    .en  (cnt_en),
    .q   (cnt)
  );

  always_comb begin
    cnt_clr = 1'b0;
    cnt_en  = 1'b0;
    if (abort) begin
      cnt_clr = 1'b1;
    end else begin
      case (state)
        TX_IDLE: cnt_clr = 1'b1;
        TX_SYNC: begin
          if (sync_last) begin
            cnt_clr = 1'b1;
            cnt_en  = xfer && !finish;
          end else begin
            cnt_en = 1'b1;
          end
        end
        TX_SEND: begin
          if (underrun || finish) cnt_clr = 1'b1;
          else                    cnt_en  = xfer;
        end
        // EOPJ spends two cycles: one to put J on the wire, one to release the bus.
        TX_EOPJ: begin
          if (cnt == 7'd0) cnt_en  = 1'b1;
          else             cnt_clr = 1'b1;
        end
        default: cnt_clr = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= TX_IDLE;
      hshake   <= 1'b0;
      bus_out  <= LINE_J;
      bus_en   <= 1'b0;
      busy     <= 1'b0;
      tx_done  <= 1'b0;
      tx_error <= 1'b0;
    end else if (abort) begin
      state    <= TX_IDLE;
      bus_out  <= LINE_J;
      bus_en   <= 1'b0;
      busy     <= 1'b0;
      tx_done  <= 1'b0;
      tx_error <= 1'b0;
    end else begin
      tx_done  <= 1'b0;
      tx_error <= 1'b0;
      case (state)
        TX_IDLE: begin
          bus_out <= LINE_J;
          bus_en  <= 1'b0;
          busy    <= 1'b0;
          if (start_send) begin
            hshake  <= send_hshake;
            state   <= TX_SYNC;
            bus_out <= sync_sym(3'd0);
            bus_en  <= 1'b1;
            busy    <= 1'b1;
          end
        end
        TX_SYNC, TX_SEND: begin
          if (state == TX_SYNC && !sync_last) begin
            bus_out <= sync_sym(cnt[2:0] + 3'd1);
          end else if (xfer) begin
            bus_out <= nrzi.s_in ? LINE_J : LINE_K;
            if (nrzi.nrzi_last) begin
              state    <= TX_EOP1;
              tx_error <= hshake && (bit_cnt_nxt != HS_LIM);
            end else if (at_limit) begin
              state    <= TX_EOP1;
              tx_error <= 1'b1;
            end else begin
              state <= TX_SEND;
            end
          end else begin
            // Underrun: no final bit to show, so the first X goes out immediately.
            bus_out  <= LINE_X;
            tx_error <= 1'b1;
            state    <= TX_EOP2;
          end
        end
        TX_EOP1: begin
          bus_out <= LINE_X;
          state   <= TX_EOP2;
        end
        TX_EOP2: begin
          bus_out <= LINE_X;
          state   <= TX_EOPJ;
        end
        TX_EOPJ: begin
          if (cnt == 7'd0) begin
            bus_out <= LINE_J;
          end else begin
            bus_en  <= 1'b0;
            busy    <= 1'b0;
            tx_done <= 1'b1;
            state   <= TX_IDLE;
          end
        end
        default: state <= TX_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tx_dpdm.sv
// tb/tb_tx_dpdm.sv - directed self-checking bench for tx_dpdm
module tb_tx_dpdm;

  localparam logic [1:0] J = 2'b10;
  localparam logic [1:0] K = 2'b01;
  localparam logic [1:0] X = 2'b00;
  localparam int MAXC = 160;

  logic       clk = 1'b0;
  logic       rst;
  logic       abort;
  logic       start_send;
  logic       send_hshake;
  logic [1:0] bus_out;
  logic       bus_en;
  logic       busy;
  logic       tx_done;
  logic       tx_error;

  tx_dpdm_if nif ();

  tx_dpdm dut (
    .clk         (clk),
    .rst         (rst),
    .abort       (abort),
    .start_send  (start_send),
    .send_hshake (send_hshake),
    .nrzi        (nif),
    .bus_out     (bus_out),
    .bus_en      (bus_en),
    .busy        (busy),
    .tx_done     (tx_done),
    .tx_error    (tx_error)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int accepted;

  // per-cycle observation {bus_out[1:0], bus_en, busy, tx_done, tx_error, nrzi_ready}
  logic [6:0] tr [MAXC];
  logic [6:0] ex [MAXC];
  logic [1:0] sync_exp [8] = '{K, J, K, J, K, J, K, K};
  logic [127:0] hs_bits = 128'h4D;
  logic [127:0] dbits;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input int idx, input int nbits, input logic [127:0] bits, input logic give_last);
    nif.nrzi_valid = (idx < nbits);
    nif.s_in       = bits[7'(idx)];
    nif.nrzi_last  = give_last && (idx == nbits - 1);
  endtask

  // Starts a packet and records ncyc cycles beginning with the first SYNC cycle.
  task automatic send_pkt(input logic hs, input int nbits, input logic [127:0] bits,
                          input logic give_last, input int ncyc, input int ss_at);
    accepted    = 0;
    send_hshake = hs;
    start_send  = 1'b1;
    drive_bit(0, nbits, bits, give_last);
    tick;
    start_send = 1'b0;
    for (int i = 0; i < ncyc; i++) begin
      tr[i] = {bus_out, bus_en, busy, tx_done, tx_error, nif.nrzi_ready};
      if (nif.nrzi_valid && nif.nrzi_ready) accepted++;
      start_send = (i == ss_at);
      tick;
      drive_bit(accepted, nbits, bits, give_last);
    end
    start_send     = 1'b0;
    nif.nrzi_valid = 1'b0;
    nif.nrzi_last  = 1'b0;
  endtask

  // Expected trace: 8 SYNC, nsh payload symbols, X X J, then release with tx_done.
  function automatic void fill_exp(input logic [127:0] bits, input int nsh, input logic urun, input logic err);
    int e0 = 8 + nsh;
    for (int i = 0; i < MAXC; i++) begin
      logic [1:0] b;
      logic act;
      act = (i < e0 + 3);
      if (i < 8)           b = sync_exp[i];
      else if (i < e0)     b = bits[7'(i - 8)] ? J : K;
      else if (i < e0 + 2) b = X;
      else                 b = J;
      ex[i] = {b, act, act, (i == e0 + 3), err && (i == (urun ? e0 : e0 - 1)),
               (i >= 7) && (i <= (urun ? e0 - 1 : e0 - 2))};
    end
  endfunction

  task automatic test_reset;
    rst = 1'b1;
    tick;
    tick;
    n_tests++;
    if ({bus_out, bus_en, busy, tx_done, tx_error, nif.nrzi_ready} !== {J, 5'b0}) begin
      n_fail++;
      $display("FAIL reset outputs got %b exp %b", {bus_out, bus_en, busy, tx_done, tx_error, nif.nrzi_ready}, {J, 5'b0});
    end
    rst = 1'b0;
    tick;
    n_tests++;
    if ({bus_out, bus_en, busy} !== {J, 2'b00}) begin
      n_fail++;
      $display("FAIL idle after reset got %b exp %b", {bus_out, bus_en, busy}, {J, 2'b00});
    end
  endtask

  task automatic test_handshake;
    fill_exp(hs_bits, 8, 1'b0, 1'b0);
    send_pkt(1'b1, 8, hs_bits, 1'b1, 26, -1);
    for (int i = 0; i < 26; i++) begin
      n_tests++;
      if (tr[i] !== ex[i]) begin
        n_fail++;
        $display("FAIL handshake cyc %0d got %b exp %b", i, tr[i], ex[i]);
      end
    end
    n_tests++;
    if (accepted !== 8) begin
      n_fail++;
      $display("FAIL handshake accepted got %0d exp 8", accepted);
    end
  endtask

  task automatic test_hshake_len;
    fill_exp(hs_bits, 5, 1'b0, 1'b1);
    send_pkt(1'b1, 5, hs_bits, 1'b1, 22, -1);
    for (int i = 0; i < 22; i++) begin
      n_tests++;
      if (tr[i] !== ex[i]) begin
        n_fail++;
        $display("FAIL hshake_len cyc %0d got %b exp %b", i, tr[i], ex[i]);
      end
    end
  endtask

  task automatic test_data_full;
    int en_cnt = 0;
    fill_exp(dbits, 101, 1'b0, 1'b0);
    send_pkt(1'b0, 101, dbits, 1'b1, 118, -1);
    for (int i = 0; i < 118; i++) begin
      if (tr[i][4]) en_cnt++;
      n_tests++;
      if (tr[i] !== ex[i]) begin
        n_fail++;
        $display("FAIL data_full cyc %0d got %b exp %b", i, tr[i], ex[i]);
      end
    end
    n_tests++;
    if (en_cnt !== 112) begin
      n_fail++;
      $display("FAIL data_full bus_en cycles got %0d exp 112", en_cnt);
    end
    n_tests++;
    if (accepted !== 101) begin
      n_fail++;
      $display("FAIL data_full accepted got %0d exp 101", accepted);
    end
  endtask

  task automatic test_underrun;
    fill_exp(dbits, 20, 1'b1, 1'b1);
    send_pkt(1'b0, 20, dbits, 1'b0, 36, -1);
    for (int i = 0; i < 36; i++) begin
      n_tests++;
      if (tr[i] !== ex[i]) begin
        n_fail++;
        $display("FAIL underrun cyc %0d got %b exp %b", i, tr[i], ex[i]);
      end
    end
  endtask

  task automatic test_overrun;
    fill_exp(dbits, 101, 1'b0, 1'b1);
    send_pkt(1'b0, 102, dbits, 1'b0, 118, -1);
    for (int i = 0; i < 118; i++) begin
      n_tests++;
      if (tr[i] !== ex[i]) begin
        n_fail++;
        $display("FAIL overrun cyc %0d got %b exp %b", i, tr[i], ex[i]);
      end
    end
    n_tests++;
    if (accepted !== 101) begin
      n_fail++;
      $display("FAIL overrun accepted got %0d exp 101", accepted);
    end
  endtask

  task automatic test_abort;
    send_pkt(1'b0, 50, dbits, 1'b0, 20, -1);
    abort = 1'b1;
    tick;
    abort = 1'b0;
    n_tests++;
    if ({bus_out, bus_en, busy, tx_done, tx_error, nif.nrzi_ready} !== {J, 5'b0}) begin
      n_fail++;
      $display("FAIL abort outputs got %b exp %b", {bus_out, bus_en, busy, tx_done, tx_error, nif.nrzi_ready}, {J, 5'b0});
    end
    for (int i = 0; i < 6; i++) begin
      tick;
      n_tests++;
      if ({bus_en, tx_done, tx_error} !== 3'b000) begin
        n_fail++;
        $display("FAIL abort quiet cyc %0d got %b exp 000", i, {bus_en, tx_done, tx_error});
      end
    end
    fill_exp(hs_bits, 8, 1'b0, 1'b0);
    send_pkt(1'b1, 8, hs_bits, 1'b1, 26, -1);
    for (int i = 0; i < 26; i++) begin
      n_tests++;
      if (tr[i] !== ex[i]) begin
        n_fail++;
        $display("FAIL after_abort cyc %0d got %b exp %b", i, tr[i], ex[i]);
      end
    end
  endtask

  task automatic test_rst_in_sync;
    send_hshake = 1'b0;
    start_send  = 1'b1;
    tick;
    start_send = 1'b0;
    tick;
    tick;
    n_tests++;
    if ({bus_out, bus_en} !== {K, 1'b1}) begin
      n_fail++;
      $display("FAIL sync before rst got %b exp %b", {bus_out, bus_en}, {K, 1'b1});
    end
    rst = 1'b1;
    tick;
    rst = 1'b0;
    n_tests++;
    if ({bus_out, bus_en, busy, tx_done, tx_error, nif.nrzi_ready} !== {J, 5'b0}) begin
      n_fail++;
      $display("FAIL rst_in_sync got %b exp %b", {bus_out, bus_en, busy, tx_done, tx_error, nif.nrzi_ready}, {J, 5'b0});
    end
    tick;
    tick;
  endtask

  task automatic test_start_ignored;
    fill_exp(hs_bits, 8, 1'b0, 1'b0);
    send_pkt(1'b1, 8, hs_bits, 1'b1, 26, 10);
    for (int i = 0; i < 26; i++) begin
      n_tests++;
      if (tr[i] !== ex[i]) begin
        n_fail++;
        $display("FAIL start_ignored cyc %0d got %b exp %b", i, tr[i], ex[i]);
      end
    end
  endtask

  initial begin
    rst            = 1'b1;
    abort          = 1'b0;
    start_send     = 1'b0;
    send_hshake    = 1'b0;
    nif.s_in       = 1'b0;
    nif.nrzi_valid = 1'b0;
    nif.nrzi_last  = 1'b0;
    for (int k = 0; k < 128; k++) dbits[k] = ((k % 3) == 0) ^ ((k % 7) == 0);

    test_reset;
    test_handshake;
    tick;
    test_hshake_len;
    tick;
    test_data_full;
    tick;
    test_underrun;
    tick;
    test_overrun;
    tick;
    test_abort;
    tick;
    test_rst_in_sync;
    test_start_ignored;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
